// File: rtl/feedthru_link_rx_if.sv
// Feedthrough link receive interface: narrow beat lane in, wide ready/valid word out.
// Signal-only bundle, no logic and no latency of its own.
// Backpressure uses out_ready only; the beat lane has no flow control.
// Optional parity lane is enabled by FEEDTHRU_PARITY_EN.
interface feedthru_link_rx_if #(
    parameter int DATA_W = 16,
    parameter int LANE_W = 4
);
    logic              link_valid;
    logic              link_sof;
    logic [LANE_W-1:0] link_data;
`ifdef FEEDTHRU_PARITY_EN
    logic              link_par;
`endif
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

`ifdef FEEDTHRU_PARITY_EN
    // Link driver and word consumer side
    modport master (
        output link_valid, link_sof, link_data, link_par, out_ready,
        input  out_valid, out_data
    );
    // Receive endpoint side
    modport slave (
        input  link_valid, link_sof, link_data, link_par, out_ready,
        output out_valid, out_data
    );
`else
    // Link driver and word consumer side
    modport master (
        output link_valid, link_sof, link_data, out_ready,
        input  out_valid, out_data
    );
    // Receive endpoint side
    modport slave (
        input  link_valid, link_sof, link_data, out_ready,
        output out_valid, out_data
    );
`endif
endinterface

// File: rtl/feedthru_link_rx.sv
// Reassembles LANE_W beats (LSB beat first, SOF on beat 0) into DATA_W words behind a 2-entry queue.
// Latency: out_valid rises the cycle after the last beat's clock edge when the queue was empty.
// Backpressure: out_ready stalls the queue only; a word completing into a full queue is dropped (err_overflow).
// Optional per-beat even parity checking is enabled by FEEDTHRU_PARITY_EN.
module feedthru_link_rx #(
    parameter int DATA_W = 16,
    parameter int LANE_W = 4,
    parameter int CNT_W  = 3
) (
    input  logic                clk_i,
    input  logic                reset_i,
    feedthru_link_rx_if.slave   lnk,
    input  logic                err_clear_i,
`ifdef FEEDTHRU_PARITY_EN
    output logic                err_parity_o,
`endif
    output logic                err_frame_o,
    output logic                err_overflow_o
);
    localparam int BEATS = DATA_W / LANE_W;

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  word_q;

    // Output queue: head_q is always what the consumer sees, tail_q the second entry.
    logic [DATA_W-1:0]  head_q, head_d;
    logic [DATA_W-1:0]  tail_q, tail_d;
    logic [1:0]         qcnt_q, qcnt_d;

    logic               err_frame_q, err_frame_d;
    logic               err_overflow_q, err_overflow_d;

    logic               is_last;
    logic               frame_evt;
    logic               frame_bad;
    logic               beat_par_err;
    logic               push_vld;
    logic               push_ok;
    logic               pop;
    logic               ovf_evt;
    logic [DATA_W-1:0]  done_word;

`ifdef FEEDTHRU_PARITY_EN
    logic               bad_q;
    logic               err_parity_q, err_parity_d;
    logic               par_evt;

    assign beat_par_err = (^lnk.link_data) ^ lnk.link_par;
    // The frame is bad if any earlier beat or the current beat failed parity.
    assign frame_bad    = bad_q | beat_par_err;
    assign par_evt      = is_last & frame_bad;
`else
    assign beat_par_err = 1'b0;
    assign frame_bad    = 1'b0;
`endif

    // A non-SOF beat in IDLE or an SOF beat mid-frame is a framing error.
    assign frame_evt = lnk.link_valid & (lnk.link_sof == (state_q == COLLECT));
    assign is_last   = (state_q == COLLECT) & lnk.link_valid & ~lnk.link_sof
                     & (cnt_q == CNT_W'(BEATS - 1));

    assign pop      = (qcnt_q != 2'd0) & lnk.out_ready;
    assign push_vld = is_last & ~frame_bad;
    // A full queue still accepts the word when the head leaves in the same cycle.
    assign push_ok  = push_vld & ((qcnt_q != 2'd2) | pop);
    assign ovf_evt  = push_vld & ~push_ok;

    // The completed word is the partial word with the final beat in the top slot.
    always_comb begin
        done_word = word_q;
        done_word[DATA_W-1 -: LANE_W] = lnk.link_data;
    end

    // Frame assembly FSM: tracks beat slot, accumulates beats, resyncs on every SOF.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
`ifdef FEEDTHRU_PARITY_EN
            bad_q   <= 1'b0;
`endif
        end else if (lnk.link_valid) begin
            if (lnk.link_sof) begin
                word_q  <= DATA_W'(lnk.link_data);
                cnt_q   <= CNT_W'(1);
                state_q <= COLLECT;
`ifdef FEEDTHRU_PARITY_EN
                bad_q   <= beat_par_err;
`endif
            end else if (state_q == COLLECT) begin
                word_q[cnt_q*LANE_W +: LANE_W] <= lnk.link_data;
`ifdef FEEDTHRU_PARITY_EN
                bad_q <= bad_q | beat_par_err;
`endif
                if (is_last) begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end else begin
                    cnt_q   <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Queue next state: shift on pop, write into the first free slot on push.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        qcnt_d = qcnt_q;
        case ({push_ok, pop})
            2'b11: begin
                if (qcnt_q == 2'd1) begin
                    head_d = done_word;
                end else begin
                    head_d = tail_q;
                    tail_d = done_word;
                end
            end
            2'b01: begin
                head_d = tail_q;
                tail_d = '0;
                qcnt_d = qcnt_q - 2'd1;
            end
            2'b10: begin
                if (qcnt_q == 2'd0) begin
                    head_d = done_word;
                end else begin
                    tail_d = done_word;
                end
                qcnt_d = qcnt_q + 2'd1;
            end
            default: begin
            end
        endcase
    end

    // Queue storage and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q <= '0;
            tail_q <= '0;
            qcnt_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            qcnt_q <= qcnt_d;
        end
    end

    // Sticky flags: an event in the same cycle as err_clear wins.
    always_comb begin
        err_frame_d    = (err_frame_q    & ~err_clear_i) | frame_evt;
        err_overflow_d = (err_overflow_q & ~err_clear_i) | ovf_evt;
`ifdef FEEDTHRU_PARITY_EN
        err_parity_d   = (err_parity_q   & ~err_clear_i) | par_evt;
`endif
    end

    // Sticky flag registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_frame_q    <= 1'b0;
            err_overflow_q <= 1'b0;
`ifdef FEEDTHRU_PARITY_EN
            err_parity_q   <= 1'b0;
`endif
        end else begin
            err_frame_q    <= err_frame_d;
            err_overflow_q <= err_overflow_d;
`ifdef FEEDTHRU_PARITY_EN
            err_parity_q   <= err_parity_d;
`endif
        end
    end

    assign lnk.out_valid  = (qcnt_q != 2'd0);
    assign lnk.out_data   = head_q;
    assign err_frame_o    = err_frame_q;
    assign err_overflow_o = err_overflow_q;
`ifdef FEEDTHRU_PARITY_EN
    assign err_parity_o   = err_parity_q;
`endif

endmodule

// File: tb/tb_feedthru_link_rx.sv
// Directed bench for feedthru_link_rx: framing, gaps, resync, backpressure, overflow, reset, parity.
// Inputs change 1 time unit after the rising edge; outputs are observed there and on the falling edge.
// Build with FEEDTHRU_PARITY_EN defined to include the parity step.
module tb_feedthru_link_rx;
    logic clk = 1'b0;
    logic reset_i;
    logic err_clear_i;
    logic err_frame_o;
    logic err_overflow_o;
`ifdef FEEDTHRU_PARITY_EN
    logic err_parity_o;
    logic par_flip = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int vld_cycles = 0;
    logic [15:0] got[$];

    feedthru_link_rx_if #(.DATA_W(16), .LANE_W(4)) lnk ();

    feedthru_link_rx #(.DATA_W(16), .LANE_W(4), .CNT_W(3)) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .lnk            (lnk),
        .err_clear_i    (err_clear_i),
`ifdef FEEDTHRU_PARITY_EN
        .err_parity_o   (err_parity_o),
`endif
        .err_frame_o    (err_frame_o),
        .err_overflow_o (err_overflow_o)
    );

    always #5 clk = ~clk;

    // Record every word transferred at the coming rising edge.
    always @(negedge clk) begin
        if (lnk.out_valid === 1'b1) vld_cycles++;
        if (lnk.out_valid === 1'b1 && lnk.out_ready === 1'b1) got.push_back(lnk.out_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One beat on the link, consumed at the next rising edge.
    task automatic beat(input logic sof, input logic [3:0] d);
        lnk.link_valid = 1'b1;
        lnk.link_sof   = sof;
        lnk.link_data  = d;
`ifdef FEEDTHRU_PARITY_EN
        lnk.link_par   = (^d) ^ par_flip;
`endif
        tick();
        lnk.link_valid = 1'b0;
        lnk.link_sof   = 1'b0;
    endtask

    task automatic frame(input logic [15:0] w);
        beat(1'b1, w[3:0]);
        beat(1'b0, w[7:4]);
        beat(1'b0, w[11:8]);
        beat(1'b0, w[15:12]);
    endtask

    task automatic clear_flags();
        err_clear_i = 1'b1;
        tick();
        err_clear_i = 1'b0;
    endtask

    initial begin
        reset_i        = 1'b1;
        err_clear_i    = 1'b0;
        lnk.link_valid = 1'b0;
        lnk.link_sof   = 1'b0;
        lnk.link_data  = '0;
`ifdef FEEDTHRU_PARITY_EN
        lnk.link_par   = 1'b0;
`endif
        lnk.out_ready  = 1'b1;
        idle(2);
        reset_i = 1'b0;

        // Reset state
        check("rst_out_valid", 32'(lnk.out_valid), 32'd0);
        check("rst_out_data", 32'(lnk.out_data), 32'd0);
        check("rst_err_frame", 32'(err_frame_o), 32'd0);
        check("rst_err_overflow", 32'(err_overflow_o), 32'd0);
        idle(1);

        // Single back-to-back frame: valid for exactly one cycle after beat 3
        got.delete();
        vld_cycles = 0;
        beat(1'b1, 4'h4);
        beat(1'b0, 4'h3);
        beat(1'b0, 4'h2);
        check("single_not_early", 32'(lnk.out_valid), 32'd0);
        beat(1'b0, 4'h1);
        check("single_valid", 32'(lnk.out_valid), 32'd1);
        check("single_data", 32'(lnk.out_data), 32'h1234);
        tick();
        check("single_valid_drop", 32'(lnk.out_valid), 32'd0);
        check("single_data_empty", 32'(lnk.out_data), 32'd0);
        idle(2);
        check("single_vld_cycles", 32'(vld_cycles), 32'd1);
        check("single_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) check("single_word", 32'(got[0]), 32'h1234);
        check("single_err_frame", 32'(err_frame_o), 32'd0);
        check("single_err_overflow", 32'(err_overflow_o), 32'd0);

        // Gapped frame: counter holds across idle cycles
        got.delete();
        beat(1'b1, 4'h4); idle(2);
        beat(1'b0, 4'h3); idle(2);
        beat(1'b0, 4'h2); idle(2);
        check("gap_not_early", 32'(lnk.out_valid), 32'd0);
        beat(1'b0, 4'h1);
        check("gap_data", 32'(lnk.out_data), 32'h1234);
        idle(2);
        check("gap_count", 32'(got.size()), 32'd1);
        check("gap_err_frame", 32'(err_frame_o), 32'd0);

        // Resync on SOF mid-frame
        got.delete();
        beat(1'b1, 4'hA);
        beat(1'b0, 4'hB);
        frame(16'h1234);
        idle(2);
        check("resync_err_frame", 32'(err_frame_o), 32'd1);
        check("resync_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) check("resync_word", 32'(got[0]), 32'h1234);
        clear_flags();
        check("clear_err_frame", 32'(err_frame_o), 32'd0);

        // Stray beat in IDLE
        got.delete();
        beat(1'b0, 4'h7);
        idle(2);
        check("stray_err_frame", 32'(err_frame_o), 32'd1);
        check("stray_count", 32'(got.size()), 32'd0);
        clear_flags();

        // Backpressure: third word dropped
        got.delete();
        lnk.out_ready = 1'b0;
        frame(16'h1111);
        frame(16'h2222);
        frame(16'h3333);
        idle(1);
        check("bp_valid", 32'(lnk.out_valid), 32'd1);
        check("bp_head_stable", 32'(lnk.out_data), 32'h1111);
        check("bp_err_overflow", 32'(err_overflow_o), 32'd1);
        check("bp_err_frame", 32'(err_frame_o), 32'd0);
        lnk.out_ready = 1'b1;
        idle(4);
        check("bp_count", 32'(got.size()), 32'd2);
        if (got.size() > 1) begin
            check("bp_word0", 32'(got[0]), 32'h1111);
            check("bp_word1", 32'(got[1]), 32'h2222);
        end
        check("bp_drained", 32'(lnk.out_valid), 32'd0);
        clear_flags();
        check("bp_clear", 32'(err_overflow_o), 32'd0);

        // Full queue, last beat coincides with a pop
        got.delete();
        lnk.out_ready = 1'b0;
        frame(16'h1111);
        frame(16'h2222);
        beat(1'b1, 4'h5);
        beat(1'b0, 4'h5);
        beat(1'b0, 4'h5);
        lnk.out_ready = 1'b1;
        beat(1'b0, 4'h5);
        check("full_pop_head", 32'(lnk.out_data), 32'h2222);
        idle(4);
        check("full_pop_overflow", 32'(err_overflow_o), 32'd0);
        check("full_pop_count", 32'(got.size()), 32'd3);
        if (got.size() > 2) begin
            check("full_pop_w0", 32'(got[0]), 32'h1111);
            check("full_pop_w1", 32'(got[1]), 32'h2222);
            check("full_pop_w2", 32'(got[2]), 32'h5555);
        end

        // Clear and framing error in the same cycle: event wins
        err_clear_i = 1'b1;
        beat(1'b0, 4'h9);
        err_clear_i = 1'b0;
        check("clear_vs_event", 32'(err_frame_o), 32'd1);
        clear_flags();
        check("clear_after", 32'(err_frame_o), 32'd0);

        // Reset mid-frame discards the partial word
        got.delete();
        beat(1'b1, 4'hE);
        beat(1'b0, 4'hD);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        frame(16'hBEEF);
        idle(2);
        check("rst_mid_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) check("rst_mid_word", 32'(got[0]), 32'hBEEF);
        check("rst_mid_err_frame", 32'(err_frame_o), 32'd0);
        check("rst_mid_err_overflow", 32'(err_overflow_o), 32'd0);

`ifdef FEEDTHRU_PARITY_EN
        // Bad parity on beat 2 suppresses the word
        got.delete();
        check("par_reset_state", 32'(err_parity_o), 32'd0);
        beat(1'b1, 4'h4);
        beat(1'b0, 4'h3);
        par_flip = 1'b1;
        beat(1'b0, 4'h2);
        par_flip = 1'b0;
        beat(1'b0, 4'h1);
        idle(2);
        check("par_count", 32'(got.size()), 32'd0);
        check("par_err_parity", 32'(err_parity_o), 32'd1);
        check("par_err_overflow", 32'(err_overflow_o), 32'd0);
        frame(16'h1234);
        idle(2);
        check("par_next_count", 32'(got.size()), 32'd1);
        clear_flags();
        check("par_clear", 32'(err_parity_o), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/feedthru_link_rx.md
Name: feedthru_link_rx

Overview:
- Receive-side endpoint of the narrow feedthrough link that carries a wide bus across a partition boundary.
- The transmit endpoint slices a DATA_W word into LANE_W-wide beats, least significant beat first, with start-of-frame marking beat 0.
- This block reassembles the beats into whole words and presents them through a 2-entry ready/valid output queue to the consuming module in the parent hierarchy.
- Framing and overflow errors are reported as sticky flags.

Parameters:
- DATA_W, 16: reassembled word width. Must be an integer multiple of LANE_W.
- LANE_W, 4: feedthrough lane width per beat. BEATS = DATA_W/LANE_W, and BEATS must be at least 2.
- CNT_W, 3: beat counter width. Must satisfy 2**CNT_W >= BEATS.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- link_valid  input  1  a beat is present on link_data this cycle.
- link_sof  input  1  start of frame; qualified by link_valid.
- link_data  input  LANE_W  beat payload.
- out_valid  output  1  out_data holds a complete word.
- out_ready  input  1  consumer accepts the word; a transfer occurs when out_valid and out_ready are both high.
- out_data  output  DATA_W  head word of the output queue.
- err_clear  input  1  clears all sticky error flags.
- err_frame  output  1  sticky framing error.
- err_overflow  output  1  sticky; a word was dropped because the queue was full.

Behaviour:
- Reset, taking effect at the next clk edge:
  - state = IDLE, beat count = 0, queue empty.
  - out_valid = 0, out_data = 0, err_frame = 0, err_overflow = 0.
  - A partial frame in progress is discarded.
- FSM states: IDLE, COLLECT. Cycles with link_valid = 0 hold all state in both states.
- IDLE:
  - link_valid & link_sof: write link_data into beat slot 0 (bits LANE_W-1:0), count = 1, go to COLLECT.
  - link_valid & !link_sof: discard the beat, set err_frame, stay in IDLE.
- COLLECT:
  - link_valid & !link_sof: write link_data into slot count (bits count*LANE_W +: LANE_W), then count++.
  - When the beat written is slot BEATS-1, the word is complete: push it to the queue and go to IDLE.
  - link_valid & link_sof: set err_frame, drop the partial word, treat this beat as slot 0 of a new frame, count = 1, stay in COLLECT.
- Latency: out_valid rises on the cycle after the last beat's clk edge when the queue was empty. Back-to-back frames sustain one word per BEATS cycles.
- Queue: 2 entries, FIFO order.
  - out_data always shows the head entry; it is 0 when the queue is empty.
  - out_data is stable while out_valid is high and out_ready is low.
  - A push is accepted when the queue is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the completed word is dropped and err_overflow is set. The FSM still returns to IDLE.
  - Simultaneous push and pop with 1 entry: occupancy stays at 1, and the new word becomes head on the next cycle.
- Sticky flags:
  - err_clear = 1 clears both flags.
  - If an error event and err_clear occur in the same cycle, the flag is set (the event wins).
  - Errors never stall reception.
- out_ready is ignored while out_valid = 0.

Optional Feature:
- Macro: FEEDTHRU_PARITY_EN.
- When defined:
  - Adds input port link_par (1 bit): even parity over link_data for each beat.
  - Adds output err_parity (1 bit, sticky, same clear rules as the other flags, reset 0).
  - Any mismatched beat in a frame marks that frame bad.
  - At completion, a bad frame is not pushed and err_parity is set; it also does not count toward err_overflow.
  - The bad mark is cleared at each new SOF and on reset.
- When not defined: link_par and err_parity do not exist, and every completed frame is pushed.

Test Plan:
- Single frame, DATA_W=16, LANE_W=4, out_ready=1: beats 0x4 (sof), 0x3, 0x2, 0x1 on consecutive cycles -> out_valid high for exactly one cycle, out_data = 0x1234, starting the cycle after beat 3; no error flags set.
- Gapped frame: same beats with 2 idle cycles between each -> out_data = 0x1234, counter holds across the gaps, no errors.
- Re-sync: 0xA (sof), 0xB, then 0x4 (sof), 0x3, 0x2, 0x1 -> err_frame = 1, single word 0x1234 output. A stray beat with no sof while in IDLE -> err_frame = 1, nothing output.
- Backpressure: out_ready=0, three frames 0x1111, 0x2222, 0x3333 -> queue holds 0x1111 and 0x2222, err_overflow = 1; raising out_ready yields 0x1111 then 0x2222 only.
- Boundary: queue full, and last beat of frame 0x5555 arrives in the same cycle as a pop -> no overflow, output order preserved, 0x5555 output last. err_clear asserted in the same cycle as a new framing error -> err_frame stays 1.
- Reset mid-frame after 2 beats, then a full frame 0xBEEF -> only 0xBEEF output, all flags 0. With FEEDTHRU_PARITY_EN: a wrong link_par on beat 2 -> no word output, err_parity = 1.
